dispatch_queue: RTL
===================

Name: dispatch_queue

Overview:
- Parametrised successor to the single-entry dispatcher: a DEPTH-entry FIFO of decoded instructions between instruction fetch and the RS/LSB/ROB.
- Issues at most one instruction per cycle from the head. Resolves source operands against the register file, the ROB and NUM_CDB broadcast buses.
- Renames rd and routes the instruction to RS or LSB.
- Decouples fetch from back-end stalls so fetch can keep streaming while the head waits.

Parameters:
- DEPTH, 4: queue entries; power of two, at least 2.
- NUM_CDB, 2: number of CDB broadcast channels.
- ROB_ID_W, 4: ROB id width. Id value 0 means no dependency.
- OPE_W, 6: instruction type code width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; when low the block freezes
- mispredict  in  1  flush request from the ROB
- if_valid  in  1  fetch offers a decoded instruction
- if_ready  out  1  queue can accept an instruction; equals !full
- if_pc, if_pred_pc  in  32 each  instruction pc and predicted next pc
- if_pred_jump  in  1  predicted taken
- if_code  in  32  raw instruction word
- if_type  in  OPE_W  decoded type
- if_is_mem  in  1  load or store; routes the instruction to the LSB
- if_rd, if_rs1, if_rs2  in  5 each  register numbers; rd is 0 when the instruction does not write
- if_imm  in  32  immediate
- rs1_to_reg, rs2_to_reg  out  5 each  combinational: head rs1/rs2
- Vj_from_reg, Vk_from_reg  in  32 each  register values
- Qj_from_reg, Qk_from_reg  in  ROB_ID_W each  register rename tags
- Qj_to_rob, Qk_to_rob  out  ROB_ID_W each  combinational: tags from the register file
- Qj_ready_from_rob, Qk_ready_from_rob  in  1 each  ROB entry holds its result
- Vj_from_rob, Vk_from_rob  in  32 each  ROB results
- cdb_valid  in  NUM_CDB  per-channel broadcast valid
- cdb_rob_id  in  NUM_CDB*ROB_ID_W  flattened broadcast ids; channel i in bits [i*W +: W]
- cdb_value  in  NUM_CDB*32  flattened broadcast values
- rob_id  in  ROB_ID_W  next free ROB id
- rob_full, rs_full, lsb_full  in  1 each  back-end full flags
- enable_to_rob, enable_to_rs, enable_to_lsb, enable_to_reg  out  1 each  registered one-cycle issue pulses
- Vj_out, Vk_out  out  32 each  issued operand values
- Qj_out, Qk_out  out  ROB_ID_W each  issued operand tags
- type_out  out  OPE_W  issued type
- imm_out  out  32  issued immediate
- pc_out, pred_pc_out  out  32 each  issued pc and predicted next pc
- code_out  out  32  issued instruction word
- pred_jump_out  out  1  issued prediction
- rd_out  out  5  issued rd
- rob_id_out  out  ROB_ID_W  ROB id assigned at issue

Behaviour:
- Reset (rst=1 at posedge) clears head, tail and count, and drives every registered output to 0.
- Reset takes priority over mispredict, which takes priority over rdy.
- mispredict=1 at posedge: same effect as reset. The queue empties, all enables go to 0, and any in-flight push is dropped.
- rdy=0: no state change. Registered outputs hold their values.
- Push: occurs when if_valid && if_ready. The entry is written at tail, and tail wraps modulo DEPTH.
- if_ready = (count != DEPTH). It does not account for a same-cycle pop, so a full queue refuses a push even while popping.
- Issue condition: count != 0, !rob_full, and (if_is_mem of the head ? !lsb_full : !rs_full).
- When the issue condition holds, the head pops and the outputs register at the posedge. Enables are high for exactly that one cycle and return to 0 on the next cycle unless another issue occurs.
- enable_to_rob is set on every issue.
- Exactly one of enable_to_rs or enable_to_lsb is set, selected by the head's if_is_mem.
- enable_to_reg is set only when rd != 0.
- Push and pop in the same cycle leave count unchanged.
- Latency: an instruction pushed into an empty queue at edge N issues at edge N+1, so the enables are visible after N+1.
- Operand resolution (j shown; k is identical):
  - Q=0: V comes from the register file and Q stays 0.
  - Otherwise, if a valid CDB channel id equals Q, take that channel's value (lowest index wins) and set Q to 0.
  - Otherwise, if the ROB reports ready, take the ROB value and set Q to 0.
  - Otherwise V=0 and Q keeps the tag.
- Resolution happens at issue time. The queue does not store operands.

Test Plan:
- Reset mid-stream: 3 entries queued, rst=1 -> count=0, if_ready=1, all enables 0 on the next cycle.
- Fill: rs_full=1, push 4 non-mem instructions -> if_ready=0 after the 4th. A 5th offer is not accepted. Release rs_full -> issues in order pc 0x0, 0x4, 0x8, 0xC on 4 consecutive cycles.
- Routing: head is_mem=1, lsb_full=1, rs_full=0 -> no issue. Drop lsb_full -> enable_to_lsb=1, enable_to_rs=0, enable_to_rob=1.
- Forwarding: Qj_from_reg=3, cdb_valid=2'b10, channel 1 id=3 with value 0xDEAD -> Vj_out=0xDEAD, Qj_out=0. Same with no CDB match and ROB not ready -> Qj_out=3, Vj_out=0.
- Rename gating: rd=0 -> enable_to_reg=0. rd=5 with rob_id=7 -> rd_out=5, rob_id_out=7, enable_to_reg=1.
- Mispredict together with push and pop -> queue empty, no issue pulse, and the pushed entry is lost.

Source files
------------

// File: rtl/dispatch_queue.sv
// Instruction queue between fetch and the back end: buffers decoded instructions, resolves
// source operands at issue time, renames rd and routes each instruction to the RS or the LSB.
module dispatch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned NUM_CDB  = 2,
    parameter int unsigned ROB_ID_W = 4,
    parameter int unsigned OPE_W    = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic                         mispredict,
    input  logic                         if_valid,
    output logic                         if_ready,
    input  logic [31:0]                  if_pc,
    input  logic [31:0]                  if_pred_pc,
    input  logic                         if_pred_jump,
    input  logic [31:0]                  if_code,
    input  logic [OPE_W-1:0]             if_type,
    input  logic                         if_is_mem,
    input  logic [4:0]                   if_rd,
    input  logic [4:0]                   if_rs1,
    input  logic [4:0]                   if_rs2,
    input  logic [31:0]                  if_imm,
    output logic [4:0]                   rs1_to_reg,
    output logic [4:0]                   rs2_to_reg,
    input  logic [31:0]                  Vj_from_reg,
    input  logic [31:0]                  Vk_from_reg,
    input  logic [ROB_ID_W-1:0]          Qj_from_reg,
    input  logic [ROB_ID_W-1:0]          Qk_from_reg,
    output logic [ROB_ID_W-1:0]          Qj_to_rob,
    output logic [ROB_ID_W-1:0]          Qk_to_rob,
    input  logic                         Qj_ready_from_rob,
    input  logic                         Qk_ready_from_rob,
    input  logic [31:0]                  Vj_from_rob,
    input  logic [31:0]                  Vk_from_rob,
    input  logic [NUM_CDB-1:0]           cdb_valid,
    input  logic [NUM_CDB*ROB_ID_W-1:0]  cdb_rob_id,
    input  logic [NUM_CDB*32-1:0]        cdb_value,
    input  logic [ROB_ID_W-1:0]          rob_id,
    input  logic                         rob_full,
    input  logic                         rs_full,
    input  logic                         lsb_full,
    output logic                         enable_to_rob,
    output logic                         enable_to_rs,
    output logic                         enable_to_lsb,
    output logic                         enable_to_reg,
    output logic [31:0]                  Vj_out,
    output logic [31:0]                  Vk_out,
    output logic [ROB_ID_W-1:0]          Qj_out,
    output logic [ROB_ID_W-1:0]          Qk_out,
    output logic [OPE_W-1:0]             type_out,
    output logic [31:0]                  imm_out,
    output logic [31:0]                  pc_out,
    output logic [31:0]                  pred_pc_out,
    output logic [31:0]                  code_out,
    output logic                         pred_jump_out,
    output logic [4:0]                   rd_out,
    output logic [ROB_ID_W-1:0]          rob_id_out
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Entry storage; contents are only meaningful between head and tail.
    logic [31:0]      r_pc        [DEPTH];
    logic [31:0]      r_pred_pc   [DEPTH];
    logic             r_pred_jump [DEPTH];
    logic [31:0]      r_code      [DEPTH];
    logic [OPE_W-1:0] r_type      [DEPTH];
    logic             r_is_mem    [DEPTH];
    logic [4:0]       r_rd        [DEPTH];
    logic [4:0]       r_rs1       [DEPTH];
    logic [4:0]       r_rs2       [DEPTH];
    logic [31:0]      r_imm       [DEPTH];

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic                r_en_rob;
    logic                r_en_rs;
    logic                r_en_lsb;
    logic                r_en_reg;
    logic [31:0]         r_vj;
    logic [31:0]         r_vk;
    logic [ROB_ID_W-1:0] r_qj;
    logic [ROB_ID_W-1:0] r_qk;
    logic [OPE_W-1:0]    r_type_out;
    logic [31:0]         r_imm_out;
    logic [31:0]         r_pc_out;
    logic [31:0]         r_pred_pc_out;
    logic [31:0]         r_code_out;
    logic                r_pred_jump_out;
    logic [4:0]          r_rd_out;
    logic [ROB_ID_W-1:0] r_rob_id_out;

    logic                w_push;
    logic                w_issue;
    logic                w_head_mem;
    logic [31:0]         w_vj;
    logic [31:0]         w_vk;
    logic [ROB_ID_W-1:0] w_qj;
    logic [ROB_ID_W-1:0] w_qk;

    // Returns {tag, value}; the lowest-index matching CDB channel wins over the ROB.
    function automatic logic [ROB_ID_W+31:0] resolve(
        input logic [ROB_ID_W-1:0] q,
        input logic [31:0]         v_reg,
        input logic                rob_ready,
        input logic [31:0]         v_rob
    );
        logic                  found;
        logic [ROB_ID_W+31:0]  res;
        found = 1'b0;
        res   = {q, 32'd0};
        if (q == '0) begin
            res = {q, v_reg};
        end else begin
            for (int i = 0; i < NUM_CDB; i++) begin
                if (!found && cdb_valid[i] && cdb_rob_id[i*ROB_ID_W +: ROB_ID_W] == q) begin
                    res   = {{ROB_ID_W{1'b0}}, cdb_value[i*32 +: 32]};
                    found = 1'b1;
                end
            end
            if (!found && rob_ready) begin
                res = {{ROB_ID_W{1'b0}}, v_rob};
            end
        end
        return res;
    endfunction

    assign if_ready   = (r_count != CNT_W'(DEPTH));
    assign w_push     = if_valid && if_ready;
    assign w_head_mem = r_is_mem[r_head];
    assign w_issue    = (r_count != '0) && !rob_full && (w_head_mem ? !lsb_full : !rs_full);

    assign rs1_to_reg = r_rs1[r_head];
    assign rs2_to_reg = r_rs2[r_head];
    assign Qj_to_rob  = Qj_from_reg;
    assign Qk_to_rob  = Qk_from_reg;

    always_comb begin
        {w_qj, w_vj} = resolve(Qj_from_reg, Vj_from_reg, Qj_ready_from_rob, Vj_from_rob);
        {w_qk, w_vk} = resolve(Qk_from_reg, Vk_from_reg, Qk_ready_from_rob, Vk_from_rob);
    end

    always_ff @(posedge clk) begin
        if (rdy && !rst && !mispredict && w_push) begin
            r_pc[r_tail]        <= if_pc;
            r_pred_pc[r_tail]   <= if_pred_pc;
            r_pred_jump[r_tail] <= if_pred_jump;
            r_code[r_tail]      <= if_code;
            r_type[r_tail]      <= if_type;
            r_is_mem[r_tail]    <= if_is_mem;
            r_rd[r_tail]        <= if_rd;
            r_rs1[r_tail]       <= if_rs1;
            r_rs2[r_tail]       <= if_rs2;
            r_imm[r_tail]       <= if_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || mispredict) begin
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= '0;
            r_en_rob        <= 1'b0;
            r_en_rs         <= 1'b0;
            r_en_lsb        <= 1'b0;
            r_en_reg        <= 1'b0;
            r_vj            <= '0;
            r_vk            <= '0;
            r_qj            <= '0;
            r_qk            <= '0;
            r_type_out      <= '0;
            r_imm_out       <= '0;
            r_pc_out        <= '0;
            r_pred_pc_out   <= '0;
            r_code_out      <= '0;
            r_pred_jump_out <= 1'b0;
            r_rd_out        <= '0;
            r_rob_id_out    <= '0;
        end else if (rdy) begin
            r_en_rob <= w_issue;
            r_en_rs  <= w_issue && !w_head_mem;
            r_en_lsb <= w_issue && w_head_mem;
            r_en_reg <= w_issue && (r_rd[r_head] != 5'd0);
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_issue) begin
                r_head          <= r_head + 1'b1;
                r_vj            <= w_vj;
                r_vk            <= w_vk;
                r_qj            <= w_qj;
                r_qk            <= w_qk;
                r_type_out      <= r_type[r_head];
                r_imm_out       <= r_imm[r_head];
                r_pc_out        <= r_pc[r_head];
                r_pred_pc_out   <= r_pred_pc[r_head];
                r_code_out      <= r_code[r_head];
                r_pred_jump_out <= r_pred_jump[r_head];
                r_rd_out        <= r_rd[r_head];
                r_rob_id_out    <= rob_id;
            end
            if (w_push && !w_issue) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_issue) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign enable_to_rob = r_en_rob;
    assign enable_to_rs  = r_en_rs;
    assign enable_to_lsb = r_en_lsb;
    assign enable_to_reg = r_en_reg;
    assign Vj_out        = r_vj;
    assign Vk_out        = r_vk;
    assign Qj_out        = r_qj;
    assign Qk_out        = r_qk;
    assign type_out      = r_type_out;
    assign imm_out       = r_imm_out;
    assign pc_out        = r_pc_out;
    assign pred_pc_out   = r_pred_pc_out;
    assign code_out      = r_code_out;
    assign pred_jump_out = r_pred_jump_out;
    assign rd_out        = r_rd_out;
    assign rob_id_out    = r_rob_id_out;

endmodule
